// File: rtl/wb_spi_front_pkg.sv
// Shared definitions for the Wishbone-to-SPI front end: the register map,
// the status-register layout and the state encodings of both FSMs.
package wb_spi_front_pkg;

    // Word addresses of the register map (address 3 is reserved)
    localparam logic [1:0] ADR_CR   = 2'd0;
    localparam logic [1:0] ADR_DATA = 2'd1;
    localparam logic [1:0] ADR_SR   = 2'd2;

    // Status register bit positions
    localparam int SR_IRQ_BIT   = 15;
    localparam int SR_BUSY_BIT  = 14;
    localparam int SR_DROP_BIT  = 13;
    localparam int SR_FULL_BIT  = 12;
    localparam int SR_EMPTY_BIT = 11;
    localparam int SR_LEVEL_LSB = 8;
    localparam int SR_LEVEL_W   = 3;

    // Bus-side FSM: wait for a request, hold an SPI strobe, acknowledge
    typedef enum logic [1:0] {
        B_IDLE,
        B_REQ,
        B_ACK
    } bus_state_e;

    // Drain FSM: move one FIFO byte into the SPI core and wait for it to finish
    typedef enum logic [1:0] {
        D_IDLE,
        D_ISSUE,
        D_WAIT_BUSY,
        D_WAIT_DONE
    } drain_state_e;

    // Assemble the status word from its individual fields
    function automatic logic [15:0] packStatus(
        input logic                  irq,
        input logic                  busy,
        input logic                  drop,
        input logic                  full,
        input logic                  empty,
        input logic [SR_LEVEL_W-1:0] level
    );
        logic [15:0] s;
        s                                = '0;
        s[SR_IRQ_BIT]                    = irq;
        s[SR_BUSY_BIT]                   = busy;
        s[SR_DROP_BIT]                   = drop;
        s[SR_FULL_BIT]                   = full;
        s[SR_EMPTY_BIT]                  = empty;
        s[SR_LEVEL_LSB +: SR_LEVEL_W]    = level;
        return s;
    endfunction

endpackage

// File: rtl/wb_spi_txfifo.sv
// Small circular TX byte FIFO. Pointers carry one extra wrap bit so that
// full and empty can be told apart without a separate counter.
module wb_spi_txfifo
    import wb_spi_front_pkg::*;
#(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  logic [7:0]            data_i,
    input  logic                  pop_i,
    output logic [7:0]            data_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DEPTH_LOG2:0]   level_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [7:0]          mem_q [DEPTH];
    logic [DEPTH_LOG2:0] wrPtr_q, wrPtr_d;
    logic [DEPTH_LOG2:0] rdPtr_q, rdPtr_d;
    logic                doPush;
    logic                doPop;

    assign empty_o = (wrPtr_q == rdPtr_q);
    assign full_o  = (wrPtr_q[DEPTH_LOG2] != rdPtr_q[DEPTH_LOG2]) &&
                     (wrPtr_q[DEPTH_LOG2-1:0] == rdPtr_q[DEPTH_LOG2-1:0]);
    assign level_o = wrPtr_q - rdPtr_q;
    assign data_o  = mem_q[rdPtr_q[DEPTH_LOG2-1:0]];

    assign doPush  = push_i && !full_o;
    assign doPop   = pop_i && !empty_o;

    // Advance each pointer independently so a push and a pop together leave the level alone
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        if (doPush) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end
        if (doPop) begin
            rdPtr_d = rdPtr_q + 1'b1;
        end
    end

    // Pointer registers; clearing them is enough to make the FIFO empty
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
        end
    end

    // Storage array; contents need no reset because the pointers gate every read
    always_ff @(posedge clk_i) begin
        if (doPush) begin
            mem_q[wrPtr_q[DEPTH_LOG2-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/wb_spi_front.sv
// Wishbone classic slave in front of the SPI interface core. Software writes
// CR through directly, bursts data bytes into a TX FIFO, and a drain engine
// hands those bytes to the core one transfer at a time.
module wb_spi_front
    import wb_spi_front_pkg::*;
#(
    parameter int DEPTH_LOG2 = 2,
    parameter int TIMEOUT    = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [1:0]  wb_adr_i,
    input  logic [15:0] wb_dat_i,
    output logic [15:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic [11:0] if_din,
    output logic        if_cmd,
    output logic        if_wr,
    output logic        if_rd,
    input  logic [9:0]  if_dout,
    input  logic        if_ack,
    input  logic        if_irq,
    output logic        irq_o
);

    localparam int              TIMER_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    bus_state_e          busState_q, busState_d;
    drain_state_e        drainState_q, drainState_d;
    logic [11:0]         shadow_q, shadow_d;
    logic [15:0]         wbDat_q, wbDat_d;
    logic                wbAck_q, wbAck_d;
    logic                wbErr_q, wbErr_d;
    logic                ifCmd_q, ifCmd_d;
    logic                ifWr_q, ifWr_d;
    logic                ifRd_q, ifRd_d;
    logic [11:0]         ifDin_q, ifDin_d;
    logic                irq_q;
    logic                dropFlag_q, dropFlag_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;

    logic                accept;
    logic                drainStart;
    logic                clearDrop;
    logic                setDrop;
    logic                fifoPush;
    logic                fifoPop;
    logic                fifoFull;
    logic                fifoEmpty;
    logic [DEPTH_LOG2:0] fifoLevel;
    logic [7:0]          fifoHead;
    logic [15:0]         statusWord;
    logic                coreBusy;

    assign coreBusy = if_dout[8];

    // A bus request is only taken while the drain engine is parked and the core is quiet
    assign accept = (busState_q == B_IDLE) && wb_cyc_i && wb_stb_i &&
                    (drainState_q == D_IDLE) && !if_ack;

    assign statusWord = packStatus(if_dout[9], coreBusy, dropFlag_q, fifoFull, fifoEmpty,
                                   SR_LEVEL_W'(fifoLevel));

    wb_spi_txfifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_txfifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .push_i  (fifoPush),
        .data_i  (wb_dat_i[7:0]),
        .pop_i   (fifoPop),
        .data_o  (fifoHead),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .level_o (fifoLevel)
    );

    // Bus FSM: decode the access, hold cmd/rd strobes until the core acks, then ack/err once
    always_comb begin
        busState_d = busState_q;
        shadow_d   = shadow_q;
        wbDat_d    = wbDat_q;
        wbAck_d    = 1'b0;
        wbErr_d    = 1'b0;
        ifCmd_d    = 1'b0;
        ifRd_d     = 1'b0;
        fifoPush   = 1'b0;
        clearDrop  = 1'b0;
        case (busState_q)
            B_IDLE: begin
                if (accept) begin
                    case (wb_adr_i)
                        ADR_CR: begin
                            if (wb_we_i) begin
                                shadow_d   = wb_dat_i[11:0];
                                ifCmd_d    = 1'b1;
                                busState_d = B_REQ;
                            end else begin
                                wbDat_d    = {4'b0, shadow_q};
                                wbAck_d    = 1'b1;
                                busState_d = B_ACK;
                            end
                        end
                        ADR_DATA: begin
                            if (wb_we_i) begin
                                if (fifoFull) begin
                                    wbErr_d = 1'b1;
                                end else begin
                                    fifoPush = 1'b1;
                                    wbAck_d  = 1'b1;
                                end
                                busState_d = B_ACK;
                            end else begin
                                ifRd_d     = 1'b1;
                                busState_d = B_REQ;
                            end
                        end
                        ADR_SR: begin
                            if (!wb_we_i) begin
                                wbDat_d   = statusWord;
                                clearDrop = 1'b1;
                            end
                            wbAck_d    = 1'b1;
                            busState_d = B_ACK;
                        end
                        default: begin
                            wbErr_d    = 1'b1;
                            busState_d = B_ACK;
                        end
                    endcase
                end
            end
            B_REQ: begin
                ifCmd_d = ifCmd_q && !if_ack;
                ifRd_d  = ifRd_q && !if_ack;
                if (if_ack) begin
                    if (ifRd_q) begin
                        wbDat_d = {8'b0, if_dout[7:0]};
                    end
                    wbAck_d    = 1'b1;
                    busState_d = B_ACK;
                end
            end
            B_ACK: begin
                busState_d = B_IDLE;
            end
            default: begin
                busState_d = B_IDLE;
            end
        endcase
    end

    // Drain FSM: pop a byte, strobe it in, then wait for busy to rise and fall (or give up)
    always_comb begin
        drainState_d = drainState_q;
        timer_d      = timer_q;
        ifWr_d       = 1'b0;
        fifoPop      = 1'b0;
        drainStart   = 1'b0;
        setDrop      = 1'b0;
        case (drainState_q)
            D_IDLE: begin
                if (!fifoEmpty && (busState_q == B_IDLE) && !accept && !if_ack && !coreBusy) begin
                    drainStart   = 1'b1;
                    fifoPop      = 1'b1;
                    ifWr_d       = 1'b1;
                    drainState_d = D_ISSUE;
                end
            end
            D_ISSUE: begin
                ifWr_d = ifWr_q && !if_ack;
                if (if_ack) begin
                    timer_d      = '0;
                    drainState_d = D_WAIT_BUSY;
                end
            end
            D_WAIT_BUSY: begin
                if (coreBusy) begin
                    drainState_d = D_WAIT_DONE;
                end else if (timer_q == TIMER_LAST) begin
                    setDrop      = 1'b1;
                    drainState_d = D_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            D_WAIT_DONE: begin
                if (!coreBusy) begin
                    drainState_d = D_IDLE;
                end
            end
            default: begin
                drainState_d = D_IDLE;
            end
        endcase
    end

    // Shared if_din register; it also serves as the holding register for the byte being drained
    always_comb begin
        ifDin_d = ifDin_q;
        if (accept && wb_we_i && (wb_adr_i == ADR_CR)) begin
            ifDin_d = wb_dat_i[11:0];
        end else if (drainStart) begin
            ifDin_d = {4'b0, fifoHead};
        end
    end

    // Drop flag: an SR read clears it, but a timeout in the same cycle takes priority
    always_comb begin
        dropFlag_d = dropFlag_q;
        if (clearDrop) begin
            dropFlag_d = 1'b0;
        end
        if (setDrop) begin
            dropFlag_d = 1'b1;
        end
    end

    // State and output registers; reset clears strobes immediately without a clock
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busState_q   <= B_IDLE;
            drainState_q <= D_IDLE;
            shadow_q     <= '0;
            wbDat_q      <= '0;
            wbAck_q      <= 1'b0;
            wbErr_q      <= 1'b0;
            ifCmd_q      <= 1'b0;
            ifWr_q       <= 1'b0;
            ifRd_q       <= 1'b0;
            ifDin_q      <= '0;
            irq_q        <= 1'b0;
            dropFlag_q   <= 1'b0;
            timer_q      <= '0;
        end else begin
            busState_q   <= busState_d;
            drainState_q <= drainState_d;
            shadow_q     <= shadow_d;
            wbDat_q      <= wbDat_d;
            wbAck_q      <= wbAck_d;
            wbErr_q      <= wbErr_d;
            ifCmd_q      <= ifCmd_d;
            ifWr_q       <= ifWr_d;
            ifRd_q       <= ifRd_d;
            ifDin_q      <= ifDin_d;
            irq_q        <= if_irq;
            dropFlag_q   <= dropFlag_d;
            timer_q      <= timer_d;
        end
    end

    assign wb_dat_o = wbDat_q;
    assign wb_ack_o = wbAck_q;
    assign wb_err_o = wbErr_q;
    assign if_din   = ifDin_q;
    assign if_cmd   = ifCmd_q;
    assign if_wr    = ifWr_q;
    assign if_rd    = ifRd_q;
    assign irq_o    = irq_q;

endmodule
